// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
// The negate helper is used both when latching operands and in the sign fix-up.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;
    localparam logic [2*DIV_WIDTH-1:0] DIV_ZERO64 = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        BUSY   = 2'd2,
        DONE   = 2'd3
    } div_state_t;

    function automatic logic [DIV_WIDTH-1:0] neg2c(input logic [DIV_WIDTH-1:0] v);
        return (~v) + DIV_WIDTH'(1);
    endfunction

endpackage

// File: rtl/div_radix2_if.sv
// Request/response bundle between the ALU (master) and the divider (slave).
// start is a level held until ready; annul aborts an outstanding divide.
interface div_radix2_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic               start;
    logic               annul;
    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic [2*WIDTH-1:0] result;
    logic               ready;

    modport master (
        output start, annul, signed_div, opdata1, opdata2,
        input  result, ready
    );

    modport slave (
        input  start, annul, signed_div, opdata1, opdata2,
        output result, ready
    );

endinterface

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} held with ready until the requester drops start.
module div_radix2
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    div_radix2_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_BYZERO = BYZERO;
    localparam logic [1:0] S_BUSY   = BUSY;
    localparam logic [1:0] S_DONE   = DONE;

    localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(WIDTH - 1);

    logic [1:0]           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q;

    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 sgn_q, sgn_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;

    logic [WIDTH:0]       trial;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quo_next;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic                 acc_sign_a;
    logic                 acc_sign_b;

    // The partial remainder never reaches 2^(WIDTH-1) before its shift, so the
    // (WIDTH+1)-bit trial subtract sees the full shifted value and its MSB is the borrow.
    always_comb begin
        trial    = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        quo_next = {dvd_q[WIDTH-2:0], q_bit};
        quo_fix  = (sgn_q && (sign_a_q ^ sign_b_q)) ? neg2c(quo_next) : quo_next;
        rem_fix  = (sgn_q && sign_a_q) ? neg2c(rem_next) : rem_next;
        acc_sign_a = bus.signed_div & bus.opdata1[WIDTH-1];
        acc_sign_b = bus.signed_div & bus.opdata2[WIDTH-1];
    end

    always_comb begin
        // NOTE: every next-state value defaults to its register first so no path
        // through the case below can leave it unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        sgn_d    = sgn_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.annul) begin
                    sgn_d    = bus.signed_div;
                    sign_a_d = acc_sign_a;
                    sign_b_d = acc_sign_b;
                    dvd_d    = acc_sign_a ? neg2c(bus.opdata1) : bus.opdata1;
                    dvs_d    = acc_sign_b ? neg2c(bus.opdata2) : bus.opdata2;
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = (bus.opdata2 == '0) ? S_BYZERO : S_BUSY;
                end
            end
            // Zero divisor spends two edges here so ready appears two cycles after acceptance.
            S_BYZERO: begin
                if (bus.annul) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d = DIV_CNT_W'(1);
                end else begin
                    result_d = DIV_ZERO64;
                    state_d  = S_DONE;
                end
            end
            S_BUSY: begin
                if (bus.annul) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_next;
                    dvd_d = quo_next;
                    cnt_d = cnt_q + DIV_CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_d = {rem_fix, quo_fix};
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!bus.start || bus.annul) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop samples
    // the pre-edge value of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= (state_d == S_DONE);
        end
    end

    // NOTE: the datapath registers are deliberately left without reset; they are
    // always loaded on acceptance before anything reads them.
    always_ff @(posedge clk) begin
        rem_q    <= rem_d;
        dvd_q    <= dvd_d;
        dvs_q    <= dvs_d;
        sgn_q    <= sgn_d;
        sign_a_q <= sign_a_d;
        sign_b_q <= sign_b_d;
    end

    assign bus.result = result_q;
    assign bus.ready  = ready_q;

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: latency, signed/unsigned results, zero divisor,
// annul and mid-divide reset, each checked against hand-computed values.
module tb_div_radix2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_radix2_if #(.WIDTH(32)) dif ();

    div_radix2 #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        dif.signed_div = sgn;
        dif.opdata1    = a;
        dif.opdata2    = b;
        dif.annul      = 1'b0;
        dif.start      = 1'b1;
    endtask

    // Returns edges from the first posedge after the call until ready, or -1 on timeout.
    task automatic wait_ready(input int budget, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (!seen && dif.ready === 1'b1) begin
                lat  = n - 1;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        launch(sgn, a, b);
        wait_ready(60, lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, dif.result, exp);
        dif.start = 1'b0;
        @(negedge clk);
        check({tag, " ready drop"}, {63'b0, dif.ready}, 64'd0);
    endtask

    initial begin
        int  lat;
        bit  ready_seen;

        rst            = 1'b1;
        dif.start      = 1'b0;
        dif.annul      = 1'b0;
        dif.signed_div = 1'b0;
        dif.opdata1    = '0;
        dif.opdata2    = '0;
        repeat (3) @(negedge clk);
        check("reset ready", {63'b0, dif.ready}, 64'd0);
        check("reset result", dif.result, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned 100/7 with operands scrambled after acceptance, result held while start stays high.
        launch(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        dif.opdata1    = 32'hDEAD_BEEF;
        dif.opdata2    = 32'h0;
        dif.signed_div = 1'b1;
        wait_ready(60, lat);
        check("divu 100/7 latency", 64'(lat + 1), 64'd32);
        check("divu 100/7 result", dif.result, 64'h00000002_0000000E);
        repeat (3) @(negedge clk);
        check("divu 100/7 ready held", {63'b0, dif.ready}, 64'd1);
        check("divu 100/7 result held", dif.result, 64'h00000002_0000000E);
        dif.start = 1'b0;
        @(negedge clk);
        check("divu 100/7 ready drop", {63'b0, dif.ready}, 64'd0);

        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD, 32);
        run_div("div 7/-2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 32);

        // Annul in the middle of BUSY: no ready, result keeps the 7/-2 value.
        launch(1'b0, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        dif.annul = 1'b1;
        dif.start = 1'b0;
        @(negedge clk);
        dif.annul  = 1'b0;
        ready_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dif.ready !== 1'b0) ready_seen = 1'b1;
        end
        check("annul no ready in 40 cycles", {63'b0, ready_seen}, 64'd0);
        check("annul result kept", dif.result, 64'h00000001_FFFFFFFD);

        run_div("divu ffffffff/1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'h00000000_FFFFFFFF, 32);
        run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 32);
        run_div("divu 80000000/ffffffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, 32);

        // Annul coinciding with the final BUSY edge wins over completion.
        launch(1'b0, 32'd100, 32'd7);
        repeat (32) @(negedge clk);
        dif.annul = 1'b1;
        @(negedge clk);
        check("annul last edge ready", {63'b0, dif.ready}, 64'd0);
        check("annul last edge result", dif.result, 64'h80000000_00000000);
        dif.annul = 1'b0;
        dif.start = 1'b0;
        @(negedge clk);

        // Synchronous reset mid-divide, then the still-high start is accepted afresh.
        launch(1'b0, 32'd1000, 32'd3);
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-divide reset ready", {63'b0, dif.ready}, 64'd0);
        check("mid-divide reset result", dif.result, 64'd0);
        rst = 1'b0;
        wait_ready(60, lat);
        check("post-reset 1000/3 latency", 64'(lat), 64'd32);
        check("post-reset 1000/3 result", dif.result, 64'h00000001_0000014D);
        dif.start = 1'b0;
        @(negedge clk);
        check("post-reset ready drop", {63'b0, dif.ready}, 64'd0);

        // Seed a nonzero result so the zero-divisor clear is observable.
        run_div("divu 100/7 again", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32);
        run_div("divu 1234/0", 1'b0, 32'h0000_1234, 32'h0000_0000, 64'd0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
